user_wb_arbiter: RTL and testbench
==================================

# user_wb_arbiter

Two-master, one-slave Wishbone arbiter inside the user project area. It shares a single user-side Wishbone slave (register bank or peripheral) between the management SoC Wishbone port (master 0) and an internal logic-analyzer-driven master (master 1). Arbitration is round-robin with grant held for the whole bus cycle. A per-transfer watchdog terminates hung transfers so the management core never stalls.

## Interface
- TIMEOUT, default 255: cycles a strobed transfer may wait for slave ack before forced termination (1..65535).
- TO_DATA, default 32'hDEAD_BEEF: read data returned on a forced termination.
- wb_clk_i  input  1  bus clock; all logic on rising edge.
- wb_rst_n  input  1  reset, asynchronous assert, active-low.
- m0_cyc_i, m0_stb_i, m0_we_i  input  1 each  master 0 cycle/strobe/write.
- m0_sel_i  input  4  master 0 byte selects.
- m0_adr_i, m0_dat_i  input  32 each  master 0 address, write data.
- m0_ack_o  output  1  master 0 acknowledge.
- m0_dat_o  output  32  master 0 read data.
- m1_* (cyc_i, stb_i, we_i, sel_i, adr_i, dat_i, ack_o, dat_o)  same directions and widths as m0, for master 1.
- s_cyc_o, s_stb_o, s_we_o  output  1 each  to slave.
- s_sel_o  output  4  to slave.
- s_adr_o, s_dat_o  output  32 each  to slave.
- s_ack_i  input  1  slave acknowledge.
- s_dat_i  input  32  slave read data.
- to_flag_o  output  1  sticky: at least one watchdog termination since last clear.
- to_clr_i  input  1  synchronous clear of to_flag_o.
- owner_o  output  2  2'b00 idle, 2'b01 master 0, 2'b10 master 1.

## Operation
- State: IDLE, OWN0, OWN1 (registered); last-owner bit `last` (reset 1, so master 0 wins first contest); 16-bit wait counter `wcnt`.
- IDLE: if only mX_cyc_i high, go to OWNX. If both high, grant the master that is not `last`. Update `last` on each grant.
- OWNX: slave outputs mirror master X combinationally (cyc, stb, we, sel, adr, dat). The non-owner's ack_o is held 0 and dat_o is 0. Owner's ack_o = s_ack_i, dat_o = s_dat_i.
- OWNX -> IDLE when mX_cyc_i is low. Grant persists across multiple strobes while cyc is held (block cycles).
- Watchdog: `wcnt` increments each cycle s_stb_o=1 and s_ack_i=0, and clears on ack, on a forced termination, or when stb is low. When `wcnt` == TIMEOUT-1 and no ack is present:
  - assert owner's ack_o for that cycle with dat_o = TO_DATA;
  - force s_stb_o and s_cyc_o to 0 for that cycle;
  - set to_flag_o.
- Ownership is unchanged by a timeout; the master must still drop cyc.
- to_flag_o: set wins over to_clr_i in the same cycle.
- Idle outputs: s_* all 0, both ack_o 0, both dat_o 0.

## Timing
- Reset values: state IDLE, owner_o 0, `last` 1, `wcnt` 0, to_flag_o 0. All s_* outputs, ack_o and dat_o are 0.
- Grant latency: cyc seen in IDLE at edge N; owner registered at N; s_cyc_o/s_stb_o high from N until next edge. Minimum one idle cycle per arbitration.
- Ack path is combinational, zero added latency once owned.
- Release: cyc low at edge N, state IDLE after N. A pending request from the other master is granted at N+1. There is no back-to-back cross-master transfer without one IDLE cycle.
- A late slave ack (after a forced termination) arriving while stb is low is dropped, not forwarded.
- Reset asserted mid-transfer: all outputs go to 0 immediately (asynchronously). The transfer is abandoned with no ack.
- Deassertion of wb_rst_n is assumed synchronized externally.

## Test plan
- Single master 0 write: adr 0x3000_0000, dat 0x1234_5678, sel 4'hF, slave acks after 2 cycles -> s_* mirror master 0, m0_ack_o pulses once, m1_ack_o stays 0, owner_o 01 then 00.
- Simultaneous requests from reset -> master 0 granted first. After it drops cyc, master 1 granted one cycle later. A second simultaneous contest grants master 1 first? No: grant goes to master 0, because `last` is now 1.
- Master 1 block read of 4 strobes with cyc held, while master 0 requests -> master 0 waits until m1_cyc_i falls. Master 1 receives all 4 s_dat_i words in order.
- Slave never acks, TIMEOUT=8 -> owner ack_o high exactly 8 cycles after stb rises, dat_o 0xDEAD_BEEF, s_stb_o low that cycle, to_flag_o 1.
- Then pulse to_clr_i -> to_flag_o 0. Timeout on the same cycle as to_clr_i -> to_flag_o stays 1.
- Reset asserted during an owned read -> s_cyc_o, s_stb_o, ack_o go 0 immediately, owner_o 00. After release, master 0 wins the next contest.

Source files
------------

// File: rtl/user_wb_arbiter.sv
// Two-master, one-slave Wishbone arbiter: round-robin grant held for the whole bus
// cycle, plus a per-transfer watchdog that forces an ack (with TO_DATA) on hung transfers.
module user_wb_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter logic [31:0] TO_DATA = 32'hDEAD_BEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic        m0_ack_o,
    output logic [31:0] m0_dat_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic        m1_ack_o,
    output logic [31:0] m1_dat_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i,
    output logic        to_flag_o,
    input  logic        to_clr_i,
    output logic [1:0]  owner_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    localparam logic [15:0] WCNT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic        last;
    logic        last_nxt;
    logic [15:0] wcnt;
    logic [15:0] wcnt_nxt;
    logic        to_flag_nxt;

    logic        own_cyc;
    logic        own_stb;
    logic        own_we;
    logic [3:0]  own_sel;
    logic [31:0] own_adr;
    logic [31:0] own_dat;
    logic        timeout;
    logic        own_ack;
    logic [31:0] own_rdat;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state     <= IDLE;
            last      <= 1'b1;
            wcnt      <= '0;
            to_flag_o <= 1'b0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            wcnt      <= wcnt_nxt;
            to_flag_o <= to_flag_nxt;
        end
    end

    // Idle presents an all-zero request so reset immediately quiets the slave side.
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_sel = '0;
        own_adr = '0;
        own_dat = '0;
        case (state)
            OWN0: begin
                own_cyc = m0_cyc_i;
                own_stb = m0_stb_i;
                own_we  = m0_we_i;
                own_sel = m0_sel_i;
                own_adr = m0_adr_i;
                own_dat = m0_dat_i;
            end
            OWN1: begin
                own_cyc = m1_cyc_i;
                own_stb = m1_stb_i;
                own_we  = m1_we_i;
                own_sel = m1_sel_i;
                own_adr = m1_adr_i;
                own_dat = m1_dat_i;
            end
            default: ;
        endcase
    end

    // Acks are gated by strobe so a late slave ack after a forced termination is dropped.
    assign timeout  = own_stb && !s_ack_i && (wcnt == WCNT_LAST);
    assign own_ack  = timeout || (own_stb && s_ack_i);
    assign own_rdat = timeout ? TO_DATA : s_dat_i;

    always_comb begin
        state_nxt   = state;
        last_nxt    = last;
        wcnt_nxt    = '0;
        to_flag_nxt = to_flag_o;
        if (own_stb && !s_ack_i && !timeout) begin
            wcnt_nxt = wcnt + 16'd1;
        end
        if (timeout) begin
            to_flag_nxt = 1'b1;
        end else if (to_clr_i) begin
            to_flag_nxt = 1'b0;
        end
        case (state)
            IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || last)) begin
                    state_nxt = OWN0;
                    last_nxt  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_nxt = OWN1;
                    last_nxt  = 1'b1;
                end
            end
            OWN0: if (!m0_cyc_i) state_nxt = IDLE;
            OWN1: if (!m1_cyc_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign s_cyc_o  = own_cyc && !timeout;
    assign s_stb_o  = own_stb && !timeout;
    assign s_we_o   = own_we;
    assign s_sel_o  = own_sel;
    assign s_adr_o  = own_adr;
    assign s_dat_o  = own_dat;

    assign m0_ack_o = (state == OWN0) && own_ack;
    assign m0_dat_o = (state == OWN0) ? own_rdat : '0;
    assign m1_ack_o = (state == OWN1) && own_ack;
    assign m1_dat_o = (state == OWN1) ? own_rdat : '0;
    assign owner_o  = state;

endmodule

// File: tb/tb_user_wb_arbiter.sv
// Directed bench for user_wb_arbiter: a cycle-level reference model checked every
// cycle, plus hand-computed expectations for latency, timeout and reset behaviour.
module tb_user_wb_arbiter;

    localparam int          TB_TIMEOUT = 8;
    localparam logic [31:0] TB_TO_DATA = 32'hDEAD_BEEF;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_adr_i, m0_dat_i;
    logic        m0_ack_o;
    logic [31:0] m0_dat_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_adr_i, m1_dat_i;
    logic        m1_ack_o;
    logic [31:0] m1_dat_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic        s_ack_i;
    logic [31:0] s_dat_i;
    logic        to_flag_o;
    logic        to_clr_i;
    logic [1:0]  owner_o;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the bus (0 none, 1 master 0, 2 master 1), which master
    // was granted most recently, how many consecutive strobed cycles went unanswered.
    int mOwner;
    int mLastGranted;
    int mWaited;
    bit mFlag;

    logic [31:0] words [4] = '{32'h1111_AAAA, 32'h2222_BBBB, 32'h3333_CCCC, 32'h4444_DDDD};

    user_wb_arbiter #(.TIMEOUT(TB_TIMEOUT), .TO_DATA(TB_TO_DATA)) dut (
        .wb_clk_i (wb_clk_i), .wb_rst_n (wb_rst_n),
        .m0_cyc_i (m0_cyc_i), .m0_stb_i (m0_stb_i), .m0_we_i (m0_we_i),
        .m0_sel_i (m0_sel_i), .m0_adr_i (m0_adr_i), .m0_dat_i (m0_dat_i),
        .m0_ack_o (m0_ack_o), .m0_dat_o (m0_dat_o),
        .m1_cyc_i (m1_cyc_i), .m1_stb_i (m1_stb_i), .m1_we_i (m1_we_i),
        .m1_sel_i (m1_sel_i), .m1_adr_i (m1_adr_i), .m1_dat_i (m1_dat_i),
        .m1_ack_o (m1_ack_o), .m1_dat_o (m1_dat_o),
        .s_cyc_o  (s_cyc_o),  .s_stb_o  (s_stb_o),  .s_we_o   (s_we_o),
        .s_sel_o  (s_sel_o),  .s_adr_o  (s_adr_o),  .s_dat_o  (s_dat_o),
        .s_ack_i  (s_ack_i),  .s_dat_i  (s_dat_i),
        .to_flag_o(to_flag_o), .to_clr_i (to_clr_i), .owner_o  (owner_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance the given number of rising edges, leaving time just past the last edge.
    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(posedge wb_clk_i);
        #1;
    endtask

    task automatic peek();
        @(negedge wb_clk_i);
        #1;
    endtask

    function automatic bit ownerStrobing();
        return (mOwner == 1 && m0_stb_i) || (mOwner == 2 && m1_stb_i);
    endfunction

    function automatic bit timeoutNow();
        return ownerStrobing() && !s_ack_i && (mWaited + 1 == TB_TIMEOUT);
    endfunction

    always @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            mOwner       = 0;
            mLastGranted = 2;
            mWaited      = 0;
            mFlag        = 1'b0;
        end else begin
            bit to;
            to = timeoutNow();
            if (ownerStrobing() && !s_ack_i && !to) mWaited = mWaited + 1;
            else mWaited = 0;
            if (to) mFlag = 1'b1;
            else if (to_clr_i) mFlag = 1'b0;
            if (mOwner == 1 && !m0_cyc_i) mOwner = 0;
            else if (mOwner == 2 && !m1_cyc_i) mOwner = 0;
            else if (mOwner == 0) begin
                if (m0_cyc_i && m1_cyc_i) mOwner = (mLastGranted == 1) ? 2 : 1;
                else if (m0_cyc_i) mOwner = 1;
                else if (m1_cyc_i) mOwner = 2;
                if (mOwner != 0) mLastGranted = mOwner;
            end
        end
    end

    always @(negedge wb_clk_i) begin
        bit to, rc, rs, rw;
        logic [3:0] rsel;
        logic [31:0] radr, rdat, rdata;
        to = timeoutNow();
        rc = 0; rs = 0; rw = 0; rsel = 0; radr = 0; rdat = 0;
        if (mOwner == 1) begin
            rc = m0_cyc_i; rs = m0_stb_i; rw = m0_we_i; rsel = m0_sel_i; radr = m0_adr_i; rdat = m0_dat_i;
        end else if (mOwner == 2) begin
            rc = m1_cyc_i; rs = m1_stb_i; rw = m1_we_i; rsel = m1_sel_i; radr = m1_adr_i; rdat = m1_dat_i;
        end
        rdata = to ? TB_TO_DATA : s_dat_i;
        checkOutput("model_owner", 32'(owner_o), (mOwner == 1) ? 32'd1 : (mOwner == 2) ? 32'd2 : 32'd0);
        checkOutput("model_s_cyc", 32'(s_cyc_o), 32'(rc && !to));
        checkOutput("model_s_stb", 32'(s_stb_o), 32'(rs && !to));
        checkOutput("model_s_we",  32'(s_we_o),  32'(rw));
        checkOutput("model_s_sel", 32'(s_sel_o), 32'(rsel));
        checkOutput("model_s_adr", s_adr_o, radr);
        checkOutput("model_s_dat", s_dat_o, rdat);
        checkOutput("model_m0_ack", 32'(m0_ack_o), 32'(mOwner == 1 && (to || (rs && s_ack_i))));
        checkOutput("model_m1_ack", 32'(m1_ack_o), 32'(mOwner == 2 && (to || (rs && s_ack_i))));
        checkOutput("model_m0_dat", m0_dat_o, (mOwner == 1) ? rdata : 32'd0);
        checkOutput("model_m1_dat", m1_dat_o, (mOwner == 2) ? rdata : 32'd0);
        checkOutput("model_to_flag", 32'(to_flag_o), 32'(mFlag));
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] bench did not finish");
    end

    initial begin
        int waited;
        wb_rst_n = 1'b0;
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = 0; m0_adr_i = 0; m0_dat_i = 0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = 0; m1_adr_i = 0; m1_dat_i = 0;
        s_ack_i = 0; s_dat_i = 0; to_clr_i = 0;
        applyStimulus(3);
        peek();
        checkOutput("rst_owner", 32'(owner_o), 32'd0);
        checkOutput("rst_flag", 32'(to_flag_o), 32'd0);
        checkOutput("rst_s_cyc", 32'(s_cyc_o), 32'd0);
        wb_rst_n = 1'b1;
        applyStimulus(1);

        // Simultaneous requests straight out of reset: master 0 first.
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_sel_i = 4'hF; m0_adr_i = 32'h3000_0010; m0_dat_i = 32'hAAAA_0000;
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_sel_i = 4'h3; m1_adr_i = 32'h3000_0020; m1_dat_i = 32'h5555_0000;
        peek();
        checkOutput("grant_latency_owner", 32'(owner_o), 32'd0);
        checkOutput("grant_latency_cyc", 32'(s_cyc_o), 32'd0);
        applyStimulus(1);
        s_ack_i = 1; s_dat_i = 32'h0BAD_F00D;
        peek();
        checkOutput("contest1_owner", 32'(owner_o), 32'd1);
        checkOutput("contest1_adr", s_adr_o, 32'h3000_0010);
        checkOutput("contest1_m0_ack", 32'(m0_ack_o), 32'd1);
        checkOutput("contest1_m1_ack", 32'(m1_ack_o), 32'd0);
        applyStimulus(1);
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        applyStimulus(1);
        peek();
        checkOutput("release_idle", 32'(owner_o), 32'd0);
        applyStimulus(1);
        s_ack_i = 1; s_dat_i = 32'hC0DE_0001;
        peek();
        checkOutput("m1_granted", 32'(owner_o), 32'd2);
        checkOutput("m1_adr", s_adr_o, 32'h3000_0020);
        checkOutput("m1_rdata", m1_dat_o, 32'hC0DE_0001);
        checkOutput("m0_dat_zero", m0_dat_o, 32'd0);
        applyStimulus(1);
        s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0; m0_cyc_i = 1; m0_stb_i = 1;
        applyStimulus(1);
        m1_cyc_i = 1; m1_stb_i = 1;
        applyStimulus(1);
        peek();
        checkOutput("contest2_owner", 32'(owner_o), 32'd1);
        m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        applyStimulus(2);

        // Single master 0 write, slave acks on the third strobed cycle.
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_sel_i = 4'hF; m0_adr_i = 32'h3000_0000; m0_dat_i = 32'h1234_5678;
        applyStimulus(1);
        peek();
        checkOutput("wr_s_adr", s_adr_o, 32'h3000_0000);
        checkOutput("wr_s_dat", s_dat_o, 32'h1234_5678);
        checkOutput("wr_s_sel", 32'(s_sel_o), 32'hF);
        checkOutput("wr_s_we", 32'(s_we_o), 32'd1);
        applyStimulus(2);
        s_ack_i = 1;
        peek();
        checkOutput("wr_m0_ack", 32'(m0_ack_o), 32'd1);
        applyStimulus(1);
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
        applyStimulus(1);
        peek();
        checkOutput("wr_release", 32'(owner_o), 32'd0);

        // Master 1 block read of four words while master 0 waits.
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_sel_i = 4'hF; m1_adr_i = 32'h3000_0100;
        applyStimulus(1);
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_adr_i = 32'h3000_0200;
        for (int i = 0; i < 4; i++) begin
            s_ack_i = 1; s_dat_i = words[i]; m1_adr_i = 32'h3000_0100 + 32'(4 * i);
            peek();
            checkOutput($sformatf("blk_data%0d", i), m1_dat_o, words[i]);
            checkOutput($sformatf("blk_owner%0d", i), 32'(owner_o), 32'd2);
            applyStimulus(1);
        end
        s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        applyStimulus(1);
        peek();
        checkOutput("blk_idle_gap", 32'(owner_o), 32'd0);
        applyStimulus(1);
        peek();
        checkOutput("blk_m0_after", 32'(owner_o), 32'd1);
        checkOutput("blk_m0_adr", s_adr_o, 32'h3000_0200);
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
        applyStimulus(2);

        // Slave never acks: forced termination on the 8th strobed cycle.
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h3000_0300;
        applyStimulus(1);
        waited = 0;
        peek();
        while (!m0_ack_o && waited < 20) begin
            applyStimulus(1);
            peek();
            waited++;
        end
        checkOutput("to_latency", 32'(waited), 32'd7);
        checkOutput("to_data", m0_dat_o, 32'hDEAD_BEEF);
        checkOutput("to_s_stb", 32'(s_stb_o), 32'd0);
        checkOutput("to_s_cyc", 32'(s_cyc_o), 32'd0);
        applyStimulus(1);
        m0_stb_i = 0; s_ack_i = 1;
        peek();
        checkOutput("to_flag_set", 32'(to_flag_o), 32'd1);
        checkOutput("late_ack_drop", 32'(m0_ack_o), 32'd0);
        checkOutput("to_owner_kept", 32'(owner_o), 32'd1);
        applyStimulus(1);
        s_ack_i = 0; m0_cyc_i = 0;
        applyStimulus(1);
        to_clr_i = 1;
        applyStimulus(1);
        to_clr_i = 0;
        peek();
        checkOutput("flag_cleared", 32'(to_flag_o), 32'd0);

        // Timeout coinciding with a clear: the set must win.
        applyStimulus(1);
        m0_cyc_i = 1; m0_stb_i = 1;
        applyStimulus(1);
        applyStimulus(7);
        to_clr_i = 1;
        peek();
        checkOutput("to2_ack", 32'(m0_ack_o), 32'd1);
        applyStimulus(1);
        to_clr_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        peek();
        checkOutput("flag_set_wins", 32'(to_flag_o), 32'd1);
        applyStimulus(2);

        // Reset mid-read abandons the transfer and re-arms master 0 priority.
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h3000_0400;
        applyStimulus(1);
        s_ack_i = 1; s_dat_i = 32'h7777_8888;
        peek();
        checkOutput("pre_rst_ack", 32'(m0_ack_o), 32'd1);
        #1;
        wb_rst_n = 1'b0;
        #1;
        checkOutput("async_rst_cyc", 32'(s_cyc_o), 32'd0);
        checkOutput("async_rst_stb", 32'(s_stb_o), 32'd0);
        checkOutput("async_rst_ack", 32'(m0_ack_o), 32'd0);
        checkOutput("async_rst_owner", 32'(owner_o), 32'd0);
        applyStimulus(1);
        wb_rst_n = 1'b1; s_ack_i = 0;
        m1_cyc_i = 1; m1_stb_i = 1;
        applyStimulus(1);
        peek();
        checkOutput("post_rst_contest", 32'(owner_o), 32'd1);
        m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        applyStimulus(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
